// File: rtl/reorder_pkg.sv
// Shared types and helpers for the FFT input reorder buffer.
package reorder_pkg;

   typedef enum logic [1:0] {
      StEmpty    = 2'd0,
      StFilling  = 2'd1,
      StFull     = 2'd2,
      StDraining = 2'd3
   } bank_state_e;

   localparam logic MODE_BITREV  = 1'b0;
   localparam logic MODE_NATURAL = 1'b1;

   // Reverses the low `width` bits of v (width up to 12); upper result bits are zero.
   function automatic logic [11:0] bitrev(input logic [11:0] v, input int unsigned width);
      logic [11:0] r;
      logic [11:0] t;
      r = '0;
      t = v;
      for (int i = 0; i < 12; i++) begin
         if (i < int'(width)) begin
            r = {r[10:0], t[0]};
            t = {1'b0, t[11:1]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reorder_skid_buf.sv
// Two-entry output FIFO carrying one reordered sample plus frame flags.
module reorder_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_free
);

   logic [W-1:0] mem_q [2];
   logic         wptr_q;
   logic         rptr_q;
   logic [1:0]   cnt_q;
   logic         push;
   logic         pop;

   always_comb begin
      pop     = i_ready && (cnt_q != 2'd0);
      push    = i_push && ((cnt_q != 2'd2) || pop);
      o_valid = (cnt_q != 2'd0);
      o_data  = mem_q[rptr_q];
      o_free  = 2'd2 - cnt_q;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (i_flush) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= i_data;
            wptr_q        <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/bitrev_pingpong_buffer.sv
// Ping-pong reorder buffer: takes natural-order frames, emits each bit-reversed or natural.
// Defining REORDER_OVERRUN_DETECT_EN adds the o_overrun / o_overrun_cnt outputs.
module bitrev_pingpong_buffer
   import reorder_pkg::*;
#(
   parameter int unsigned LOG2N = 10,
   parameter int unsigned DW    = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic          i_mode,
   input  logic [DW-1:0] i_data_real,
   input  logic [DW-1:0] i_data_imag,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data_real,
   output logic [DW-1:0] o_data_imag,
   output logic          o_first,
   output logic          o_last
`ifdef REORDER_OVERRUN_DETECT_EN
   ,
   output logic          o_overrun,
   output logic [15:0]   o_overrun_cnt
`endif
);

   localparam int unsigned N  = 1 << LOG2N;
   localparam int unsigned SW = 2 * DW + 2;

   bank_state_e      st_q [2];
   bank_state_e      st_d [2];
   logic             wr_bank_q;
   logic             rd_bank_q;
   logic [LOG2N-1:0] wr_cnt_q;
   logic [LOG2N-1:0] rd_cnt_q;
   logic [LOG2N-1:0] rd_addr;
   logic [1:0]       mode_q;
   logic             rd_valid_q;
   logic             rd_first_q;
   logic             rd_last_q;
   logic [DW-1:0]    rd_real_q;
   logic [DW-1:0]    rd_imag_q;
   logic [DW-1:0]    mem_real [2][N];
   logic [DW-1:0]    mem_imag [2][N];
   logic             in_xfer;
   logic             rd_active;
   logic             rd_issue;
   logic             rd_done;
   logic             out_pop;
   logic [1:0]       skid_free;
   logic [1:0]       free_eff;
   logic [SW-1:0]    skid_data;

   always_comb begin
      out_pop   = o_valid & i_ready;
      // A pop this cycle frees a slot for a read issued this cycle.
      free_eff  = skid_free + {1'b0, out_pop};
      rd_active = (st_q[rd_bank_q] == StFull) || (st_q[rd_bank_q] == StDraining);
      rd_issue  = rd_active && (free_eff > {1'b0, rd_valid_q}) && !i_flush;
      rd_done   = rd_issue && (&rd_cnt_q);
      // Final read of the target bank frees it this cycle, so writing can resume without a bubble.
      o_ready   = (st_q[wr_bank_q] == StEmpty) || (st_q[wr_bank_q] == StFilling) ||
                  (rd_done && (rd_bank_q == wr_bank_q));
      in_xfer   = i_valid && o_ready && !i_flush;
      rd_addr   = (mode_q[rd_bank_q] == MODE_BITREV) ?
                  LOG2N'(bitrev(12'(rd_cnt_q), LOG2N)) : rd_cnt_q;
      st_d[0] = st_q[0];
      st_d[1] = st_q[1];
      if (rd_issue) begin
         st_d[rd_bank_q] = rd_done ? StEmpty : StDraining;
      end
      if (in_xfer) begin
         st_d[wr_bank_q] = (&wr_cnt_q) ? StFull : StFilling;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         st_q[0]    <= StEmpty;
         st_q[1]    <= StEmpty;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         mode_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_first_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else if (i_flush) begin
         st_q[0]    <= StEmpty;
         st_q[1]    <= StEmpty;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         mode_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_first_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
         if (in_xfer) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (&wr_cnt_q) begin
               wr_bank_q <= ~wr_bank_q;
            end
            if (wr_cnt_q == '0) begin
               mode_q[wr_bank_q] <= i_mode;
            end
         end
         if (rd_issue) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_done) begin
               rd_bank_q <= ~rd_bank_q;
            end
         end
         rd_valid_q <= rd_issue;
         rd_first_q <= (rd_cnt_q == '0);
         rd_last_q  <= (&rd_cnt_q);
      end
   end

   // Sample storage is never reset; contents after reset or flush are don't-care.
   always_ff @(posedge i_clk) begin
      if (in_xfer) begin
         mem_real[wr_bank_q][wr_cnt_q] <= i_data_real;
         mem_imag[wr_bank_q][wr_cnt_q] <= i_data_imag;
      end
      if (rd_issue) begin
         rd_real_q <= mem_real[rd_bank_q][rd_addr];
         rd_imag_q <= mem_imag[rd_bank_q][rd_addr];
      end
   end

   reorder_skid_buf #(
      .W(SW)
   ) u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_flush),
      .i_push  (rd_valid_q),
      .i_data  ({rd_real_q, rd_imag_q, rd_first_q, rd_last_q}),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (skid_data),
      .o_free  (skid_free)
   );

   assign {o_data_real, o_data_imag, o_first, o_last} = skid_data;

`ifdef REORDER_OVERRUN_DETECT_EN
   logic        ovr_q;
   logic [15:0] ovr_cnt_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ovr_q     <= 1'b0;
         ovr_cnt_q <= '0;
      end else if (i_flush) begin
         ovr_q     <= 1'b0;
         ovr_cnt_q <= '0;
      end else begin
         ovr_q <= i_valid & ~o_ready;
         if (i_valid && !o_ready && !(&ovr_cnt_q)) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
         end
      end
   end

   assign o_overrun     = ovr_q;
   assign o_overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_bitrev_pingpong_buffer.sv
// Self-checking bench for bitrev_pingpong_buffer (8-point frames) with a frame-level scoreboard.
module tb_bitrev_pingpong_buffer;

   localparam int unsigned L  = 3;
   localparam int          NN = 8;
   localparam int unsigned W  = 16;
   localparam int          IM = 'h1000;

   typedef struct {
      int re;
      int im;
      bit first;
      bit last;
   } exp_t;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic         i_flush;
   logic         i_valid;
   logic         o_ready;
   logic         i_mode;
   logic [W-1:0] i_data_real;
   logic [W-1:0] i_data_imag;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_data_real;
   logic [W-1:0] o_data_imag;
   logic         o_first;
   logic         o_last;
`ifdef REORDER_OVERRUN_DETECT_EN
   logic         o_overrun;
   logic [15:0]  o_overrun_cnt;
`endif

   bitrev_pingpong_buffer #(
      .LOG2N(L),
      .DW   (W)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_flush     (i_flush),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_mode      (i_mode),
      .i_data_real (i_data_real),
      .i_data_imag (i_data_imag),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data_real (o_data_real),
      .o_data_imag (o_data_imag),
      .o_first     (o_first),
      .o_last      (o_last)
`ifdef REORDER_OVERRUN_DETECT_EN
      ,
      .o_overrun     (o_overrun),
      .o_overrun_cnt (o_overrun_cnt)
`endif
   );

   initial forever #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 2;  // 0: always ready, 1: random, 2: driven by the test sequence
   exp_t expq[$];
   int   cap[$];
   int   fr[NN];
   int   fidx = 0;
   bit   fmode = 0;
   bit   hold_v = 0;
   int   hold_d = 0;
   bit   saw_nr = 0;
   int   first_valid_cyc = -1;
   int   last_acc_cyc = -1;

   function automatic int rev(input int k);
      int r = 0;
      for (int b = 0; b < int'(L); b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon_step();
      exp_t e;
      if (!i_reset) begin
         hold_v = 0;
         return;
      end
      if (i_flush) begin
         expq.delete();
         fidx   = 0;
         hold_v = 0;
         return;
      end
      if (!o_ready) saw_nr = 1;
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hold_v) begin
         chk("hold_valid", o_valid, 1);
         chk("hold_data", o_data_real, hold_d);
      end
      if (o_valid && i_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_output", o_data_real, -1);
         end else begin
            e = expq.pop_front();
            chk("out_real", o_data_real, e.re);
            chk("out_imag", o_data_imag, e.im);
            chk("out_first", o_first, e.first);
            chk("out_last", o_last, e.last);
         end
         cap.push_back(int'(o_data_real));
      end
      hold_v = o_valid && !i_ready;
      hold_d = int'(o_data_real);
      if (i_valid && o_ready) begin
         if (fidx == 0) fmode = i_mode;
         fr[fidx] = int'(i_data_real);
         if (fidx == NN - 1) begin
            last_acc_cyc = cyc;
            for (int k = 0; k < NN; k++) begin
               e.re    = fmode ? fr[k] : fr[rev(k)];
               e.im    = e.re + IM;
               e.first = (k == 0);
               e.last  = (k == NN - 1);
               expq.push_back(e);
            end
            fidx = 0;
         end else begin
            fidx++;
         end
      end
   endtask

   task automatic put(input int v, input logic m);
      bit ok = 0;
      int g = 0;
      i_valid     = 1'b1;
      i_data_real = W'(v);
      i_data_imag = W'(v + IM);
      i_mode      = m;
      while (!ok && g < 500) begin
         @(negedge i_clk);
         ok = o_ready;
         g++;
         @(posedge i_clk);
         #1;
      end
      chk("put_accepted", ok, 1);
   endtask

   task automatic wait_drain();
      int g = 0;
      while ((expq.size() != 0 || o_valid) && g < 3000) begin
         @(posedge i_clk);
         #1;
         g++;
      end
      chk("drain_left", expq.size(), 0);
   endtask

   task automatic run_tests();
      int lit1[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
      int lit2[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 10, 14, 9, 13, 11, 15};
      int n0;
      int g;

      i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_mode = 1'b0;
      i_data_real = '0; i_data_imag = '0; i_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_first", o_first, 0);
      chk("rst_o_last", o_last, 0);
      chk("rst_o_data_real", o_data_real, 0);
      chk("rst_o_data_imag", o_data_imag, 0);
      chk("rst_o_ready", o_ready, 1);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;

      // Single bit-reversed frame, continuous input.
      for (int i = 0; i < NN; i++) put(i, 1'b0);
      i_valid = 1'b0;
      wait_drain();
      chk("t1_count", cap.size(), 8);
      for (int i = 0; i < 8 && i < cap.size(); i++) chk("t1_order", cap[i], lit1[i]);
      chk("t1_first_valid_edges", first_valid_cyc - last_acc_cyc - 1, 2);

      // Natural frame then bit-reversed frame with mode toggled mid-frame.
      n0 = cap.size();
      for (int i = 0; i < NN; i++) put(i, 1'b1);
      for (int i = 0; i < NN; i++) put(8 + i, (i >= 4));
      i_valid = 1'b0;
      wait_drain();
      chk("t2_count", cap.size() - n0, 16);
      for (int i = 0; i < 16 && n0 + i < cap.size(); i++) chk("t2_order", cap[n0 + i], lit2[i]);

      // Three back-to-back frames with a 5-cycle stall on the 2nd output sample.
      n0 = cap.size();
      saw_nr = 0;
      fork
         begin
            for (int f = 0; f < 3; f++)
               for (int i = 0; i < NN; i++) put(16 + f * NN + i, 1'b0);
            i_valid = 1'b0;
         end
         begin
            g = 0;
            while (cap.size() < n0 + 1 && g < 200) begin
               @(posedge i_clk);
               #1;
               g++;
            end
            chk("t3_first_out_seen", cap.size() >= n0 + 1, 1);
            i_ready = 1'b0;
            repeat (5) @(posedge i_clk);
            #1;
            i_ready = 1'b1;
         end
      join
      wait_drain();
      chk("t3_count", cap.size() - n0, 24);
      chk("t3_ready_dropped", saw_nr, 1);

      // Random bubbles and backpressure over 20 frames.
      n0 = cap.size();
      rdy_mode = 1;
      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < NN; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               i_valid = 1'b0;
               @(posedge i_clk);
               #1;
            end
            put(100 + f * NN + i, 1'b0);
         end
      end
      i_valid = 1'b0;
      rdy_mode = 0;
      wait_drain();
      rdy_mode = 2;
      i_ready = 1'b1;
      chk("t4_count", cap.size() - n0, 160);

      // Flush while frame 0 drains and frame 1 is partial.
      for (int i = 0; i < NN; i++) put('h40 + i, 1'b0);
      for (int i = 0; i < 5; i++) put('h48 + i, 1'b0);
      chk("t5_draining_before_flush", o_valid, 1);
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("t5_flush_o_valid", o_valid, 0);
      chk("t5_flush_o_ready", o_ready, 1);
      chk("t5_flush_o_first", o_first, 0);
      i_ready = 1'b1;
      n0 = cap.size();
      for (int i = 0; i < NN; i++) put('h50 + i, 1'b0);
      i_valid = 1'b0;
      wait_drain();
      chk("t5_count", cap.size() - n0, 8);
      if (cap.size() >= n0 + 8) begin
         chk("t5_sample0", cap[n0], 'h50);
         chk("t5_sample1", cap[n0 + 1], 'h54);
         chk("t5_sample7", cap[n0 + 7], 'h57);
      end

`ifdef REORDER_OVERRUN_DETECT_EN
      // Overrun counting with both banks held occupied.
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("t6_cnt_cleared", o_overrun_cnt, 0);
      i_ready = 1'b0;
      for (int i = 0; i < 2 * NN; i++) put('h60 + i, 1'b0);
      i_valid = 1'b1;
      i_data_real = W'('h7F);
      repeat (4) @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      chk("t6_ready_low", o_ready, 0);
      chk("t6_overrun_pulse", o_overrun, 1);
      chk("t6_overrun_cnt", o_overrun_cnt, 4);
      @(posedge i_clk);
      #1;
      chk("t6_overrun_clear", o_overrun, 0);
      chk("t6_cnt_held", o_overrun_cnt, 4);
      i_ready = 1'b1;
      wait_drain();
`endif
   endtask

   initial begin
      fork
         forever begin
            @(negedge i_clk);
            mon_step();
         end
         forever begin
            @(posedge i_clk);
            #1;
            if (rdy_mode == 0) i_ready = 1'b1;
            else if (rdy_mode == 1) i_ready = 1'($urandom_range(0, 1));
         end
         run_tests();
         begin
            #2000000;
            chk("watchdog_timeout", 1, 0);
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
